// File: rtl/pulse_voice_pkg.sv
// Shared widths, duty encodings and the duty-to-threshold table for the pulse voice back end.
package pulse_voice_pkg;

  localparam int unsigned PHASE_W  = 32;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned ENV_W    = 9;

  localparam logic [1:0] DUTY_12 = 2'd0;
  localparam logic [1:0] DUTY_25 = 2'd1;
  localparam logic [1:0] DUTY_50 = 2'd2;
  localparam logic [1:0] DUTY_75 = 2'd3;

  // Compared against the top three phase bits: high while phase[31:29] < threshold.
  function automatic logic [2:0] duty_thr(input logic [1:0] duty);
    logic [2:0] thr;
    thr = 3'd1;
    case (duty)
      DUTY_12: thr = 3'd1;
      DUTY_25: thr = 3'd2;
      DUTY_50: thr = 3'd4;
      DUTY_75: thr = 3'd6;
      default: thr = 3'd1;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/pulse_voice_pwm_if.sv
// Channel-sequencer-to-voice bundle: top/phase/envelope/duty in, PWM audio and period status out.
interface pulse_voice_pwm_if;
  import pulse_voice_pkg::*;

  logic [SAMPLE_W-1:0] i_top;
  logic                i_top_valid;
  logic [PHASE_W-1:0]  i_phase_delta;
  logic [ENV_W-1:0]    i_envelope;
  logic [1:0]          i_duty;
  logic                o_pwm;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_period_start;

  modport master (
    output i_top, i_top_valid, i_phase_delta, i_envelope, i_duty,
    input  o_pwm, o_sample, o_period_start
  );

  modport slave (
    input  i_top, i_top_valid, i_phase_delta, i_envelope, i_duty,
    output o_pwm, o_sample, o_period_start
  );
endinterface

// File: rtl/pwm_modulator.sv
// Single-bit PWM with period top+1; top and sample are latched only on period boundaries.
module pwm_modulator
  import pulse_voice_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] TOP_RESET = 8'hFF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [SAMPLE_W-1:0] i_top,
  input  logic                i_top_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_pwm,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_period_start
);

  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] top_q, top_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                pwm_q, pwm_d;
  logic                start_q, start_d;
  logic                wrap;
  logic [SAMPLE_W-1:0] pend_eff;

  always_comb begin
    wrap     = (cnt_q == top_q);
    // A top arriving on the boundary cycle takes effect immediately.
    pend_eff = i_top_valid ? i_top : pend_q;
    pend_d   = pend_eff;
    cnt_d    = wrap ? '0 : cnt_q + 8'd1;
    top_d    = wrap ? pend_eff : top_q;
    sample_d = wrap ? i_sample : sample_q;
    start_d  = wrap;
    pwm_d    = (cnt_d < sample_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      top_q    <= TOP_RESET;
      pend_q   <= TOP_RESET;
      sample_q <= '0;
      pwm_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      top_q    <= top_d;
      pend_q   <= pend_d;
      sample_q <= sample_d;
      pwm_q    <= pwm_d;
      start_q  <= start_d;
    end
  end

  assign o_pwm          = pwm_q;
  assign o_sample       = sample_q;
  assign o_period_start = start_q;

endmodule

// File: rtl/pulse_voice_pwm.sv
// Pulse voice: phase accumulator -> duty-compared pulse -> envelope scale -> PWM modulator.
module pulse_voice_pwm
  import pulse_voice_pkg::*;
#(
  parameter int unsigned         ENV_SHIFT = 5,
  parameter logic [SAMPLE_W-1:0] TOP_RESET = 8'hFF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pulse_voice_pwm_if.slave bus
);

  localparam int unsigned PROD_W = SAMPLE_W + ENV_W;

  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic                wave_q, wave_d;
  logic [SAMPLE_W-1:0] scaled_q, scaled_d;
  logic [PROD_W-1:0]   product;
  logic [PROD_W-1:0]   shifted;

  always_comb begin
    phase_d  = phase_q + bus.i_phase_delta;
    wave_d   = (phase_q[PHASE_W-1 -: 3] < duty_thr(bus.i_duty));
    product  = {{ENV_W{1'b0}}, {SAMPLE_W{wave_q}}} * {{SAMPLE_W{1'b0}}, bus.i_envelope};
    shifted  = product >> ENV_SHIFT;
    // Saturate rather than wrap when the envelope exceeds full scale.
    scaled_d = (|shifted[PROD_W-1:SAMPLE_W]) ? '1 : shifted[SAMPLE_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase_q  <= '0;
      wave_q   <= 1'b0;
      scaled_q <= '0;
    end else begin
      phase_q  <= phase_d;
      wave_q   <= wave_d;
      scaled_q <= scaled_d;
    end
  end

  logic                pwm_w;
  logic [SAMPLE_W-1:0] sample_w;
  logic                start_w;

  pwm_modulator #(
    .TOP_RESET(TOP_RESET)
  ) u_pwm (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_top         (bus.i_top),
    .i_top_valid   (bus.i_top_valid),
    .i_sample      (scaled_q),
    .o_pwm         (pwm_w),
    .o_sample      (sample_w),
    .o_period_start(start_w)
  );

  assign bus.o_pwm          = pwm_w;
  assign bus.o_sample       = sample_w;
  assign bus.o_period_start = start_w;

endmodule

// File: tb/tb_pulse_voice_pwm.sv
// Self-checking bench for pulse_voice_pwm against a cycle-level behavioural model of the voice.
module tb_pulse_voice_pwm;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pulse_voice_pwm_if bus();

  pulse_voice_pwm dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int          thr_tab [4] = '{1, 2, 4, 6};
  logic [31:0] m_phase;
  logic        m_wave;
  logic [7:0]  m_scaled;
  logic [7:0]  m_sample;
  logic [7:0]  m_top;
  logic [7:0]  m_pend;
  int          m_pos;
  logic        m_pwm;
  logic        m_start;

  task automatic model_step();
    int         sc;
    logic       nw;
    logic [7:0] pend_now;
    if (rst) begin
      m_phase = 0; m_wave = 0; m_scaled = 0; m_sample = 0;
      m_top = 8'hFF; m_pend = 8'hFF; m_pos = 0; m_pwm = 0; m_start = 0;
    end else begin
      sc = m_wave ? (255 * int'(bus.i_envelope)) / 32 : 0;
      if (sc > 255) sc = 255;
      nw = int'(m_phase / 32'h2000_0000) < thr_tab[bus.i_duty];
      m_phase = m_phase + bus.i_phase_delta;
      pend_now = bus.i_top_valid ? bus.i_top : m_pend;
      if (m_pos == int'(m_top)) begin
        m_pos = 0; m_top = pend_now; m_sample = m_scaled; m_start = 1;
      end else begin
        m_pos = m_pos + 1; m_start = 0;
      end
      m_pend = pend_now;
      m_wave = nw;
      m_scaled = 8'(sc);
      m_pwm = (m_pos < int'(m_sample));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int last;
    rst = 1'b1;
    bus.i_top = 8'd0; bus.i_top_valid = 1'b0; bus.i_phase_delta = $urandom;
    bus.i_envelope = 9'd0; bus.i_duty = 2'($urandom_range(0, 3));
    tick();
    n_vec++; if (bus.o_pwm !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", bus.o_pwm); end
    n_vec++; if (bus.o_sample !== 8'd0) begin n_err++; $display("FAIL reset_sample: got %0d want 0", bus.o_sample); end
    n_vec++; if (bus.o_period_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.o_period_start); end
    rst = 1'b0;
    last = -1;
    for (int i = 0; i < 800; i++) begin
      tick();
      n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL idle_pwm @%0d: got %b want %b", i, bus.o_pwm, m_pwm); end
      n_vec++; if (bus.o_sample !== m_sample) begin n_err++; $display("FAIL idle_sample @%0d: got %0d want %0d", i, bus.o_sample, m_sample); end
      n_vec++; if (bus.o_period_start !== m_start) begin n_err++; $display("FAIL idle_start @%0d: got %b want %b", i, bus.o_period_start, m_start); end
      if (bus.o_period_start === 1'b1) begin
        if (last >= 0) begin
          n_vec++;
          if (i - last != 256) begin n_err++; $display("FAIL idle_period: got %0d want 256", i - last); end
        end
        last = i;
      end
    end
  endtask

  task automatic test_wave_scale();
    int highs;
    int env_tab [4] = '{32, 16, 40, 32};
    int duty_tab [4] = '{2, 2, 2, 0};
    // Select top=0 so o_sample follows the scaled value every clock.
    bus.i_top = 8'd0; bus.i_top_valid = 1'b1;
    tick();
    bus.i_top_valid = 1'b0;
    for (int i = 0; i < 260; i++) tick();
    bus.i_phase_delta = 32'h1000_0000;
    for (int s = 0; s < 4; s++) begin
      bus.i_envelope = 9'(env_tab[s]);
      bus.i_duty = 2'(duty_tab[s]);
      highs = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL wave_pwm s%0d @%0d: got %b want %b", s, i, bus.o_pwm, m_pwm); end
        n_vec++; if (bus.o_sample !== m_sample) begin n_err++; $display("FAIL wave_sample s%0d @%0d: got %0d want %0d", s, i, bus.o_sample, m_sample); end
        n_vec++; if (bus.o_period_start !== 1'b1) begin n_err++; $display("FAIL wave_start s%0d @%0d: got %b want 1", s, i, bus.o_period_start); end
        if (i >= 8 && bus.o_sample !== 8'd0) highs++;
      end
      n_vec++;
      if (highs != ((duty_tab[s] == 0) ? 4 : 16)) begin
        n_err++; $display("FAIL wave_duty s%0d: got %0d high want %0d", s, highs, (duty_tab[s] == 0) ? 4 : 16);
      end
    end
  endtask

  task automatic test_top_defer();
    int starts [$];
    bus.i_envelope = 9'd16; bus.i_duty = 2'd3;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin bus.i_top = 8'd5; bus.i_top_valid = 1'b1; end
      else if (i == 3) begin bus.i_top = 8'd3; bus.i_top_valid = 1'b1; end
      else bus.i_top_valid = 1'b0;
      tick();
      n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL defer_pwm @%0d: got %b want %b", i, bus.o_pwm, m_pwm); end
      n_vec++; if (bus.o_sample !== m_sample) begin n_err++; $display("FAIL defer_sample @%0d: got %0d want %0d", i, bus.o_sample, m_sample); end
      n_vec++; if (bus.o_period_start !== m_start) begin n_err++; $display("FAIL defer_start @%0d: got %b want %b", i, bus.o_period_start, m_start); end
      if (bus.o_period_start === 1'b1) starts.push_back(i);
    end
    bus.i_top_valid = 1'b0;
    n_vec++;
    if (starts.size() < 3) begin
      n_err++; $display("FAIL defer_count: got %0d starts want >=3", starts.size());
    end else begin
      n_vec++;
      if (starts[1] - starts[0] != 6) begin n_err++; $display("FAIL defer_old_top: got %0d want 6", starts[1] - starts[0]); end
      if (starts[2] - starts[1] != 4) begin n_err++; $display("FAIL defer_new_top: got %0d want 4", starts[2] - starts[1]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.i_phase_delta = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 32'h0800_0000));
      if ($urandom_range(0, 7) == 0) bus.i_envelope = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) bus.i_duty = 2'($urandom_range(0, 3));
      bus.i_top_valid = ($urandom_range(0, 15) == 0);
      bus.i_top = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      tick();
      n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL rand_pwm @%0d: got %b want %b", i, bus.o_pwm, m_pwm); end
      n_vec++; if (bus.o_sample !== m_sample) begin n_err++; $display("FAIL rand_sample @%0d: got %0d want %0d", i, bus.o_sample, m_sample); end
      n_vec++; if (bus.o_period_start !== m_start) begin n_err++; $display("FAIL rand_start @%0d: got %b want %b", i, bus.o_period_start, m_start); end
    end
    bus.i_top_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    bus.i_top = 8'd9; bus.i_top_valid = 1'b1;
    bus.i_envelope = 9'd16; bus.i_duty = 2'd3; bus.i_phase_delta = 32'h1000_0000;
    tick();
    bus.i_top_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      tick();
      n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL mid_pwm @%0d: got %b want %b", i, bus.o_pwm, m_pwm); end
      if (m_pwm && m_pos > 2) found = 1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL mid_wait: got timeout want pwm high mid-period"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.o_pwm !== 1'b0) begin n_err++; $display("FAIL mid_reset_pwm: got %b want 0", bus.o_pwm); end
    n_vec++; if (bus.o_sample !== 8'd0) begin n_err++; $display("FAIL mid_reset_sample: got %0d want 0", bus.o_sample); end
    n_vec++; if (bus.o_period_start !== 1'b0) begin n_err++; $display("FAIL mid_reset_start: got %b want 0", bus.o_period_start); end
    for (int i = 0; i < 300; i++) begin
      tick();
      n_vec++; if (bus.o_pwm !== m_pwm) begin n_err++; $display("FAIL post_pwm @%0d: got %b want %b", i, bus.o_pwm, m_pwm); end
      n_vec++; if (bus.o_sample !== m_sample) begin n_err++; $display("FAIL post_sample @%0d: got %0d want %0d", i, bus.o_sample, m_sample); end
      n_vec++; if (bus.o_period_start !== m_start) begin n_err++; $display("FAIL post_start @%0d: got %b want %b", i, bus.o_period_start, m_start); end
      if (i == 255) begin
        n_vec++;
        if (bus.o_period_start !== 1'b1) begin n_err++; $display("FAIL post_top_ff: got %b want 1", bus.o_period_start); end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_top = '0; bus.i_top_valid = 1'b0; bus.i_phase_delta = '0;
    bus.i_envelope = '0; bus.i_duty = '0;
    test_reset();
    test_wave_scale();
    test_top_defer();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
